// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants and GF(2^8) helpers
package aes_pkg;

    localparam int NR      = 10;
    localparam int BLOCK_W = 128;

    typedef enum logic [2:0] {IDLE, EXPAND, INIT, ROUND, DONE} state_t;

    // Entry 0 is never used; indices 1..10 match the expansion cycle number.
    localparam logic [7:0] RCON [0:10] = '{8'h8d, 8'h01, 8'h02, 8'h04, 8'h08,
                                          8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
        return gmul(r, r);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               last,
    output logic [BLOCK_W-1:0] next_state
);

    logic [7:0] b [0:15];

    // Byte j sits at row j%4, column j/4; row r is rotated right by r columns.
    always_comb begin
        for (int j = 0; j < 16; j++) begin
            b[j] = inv_sbox(state[127 - 8*(4*(((j/4) + 4 - (j%4)) % 4) + (j%4)) -: 8])
                   ^ round_key[127 - 8*j -: 8];
        end
        next_state = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                next_state[127 - 8*(4*c + r) -: 8] = last ? b[4*c + r] :
                    gmul(b[4*c + r], 8'h0e)           ^ gmul(b[4*c + (r+1)%4], 8'h0b) ^
                    gmul(b[4*c + (r+2)%4], 8'h0d)     ^ gmul(b[4*c + (r+3)%4], 8'h09);
            end
        end
    end

endmodule

// File: rtl/aes128_iter_decrypt.sv
// rtl/aes128_iter_decrypt.sv - iterative AES-128 decryptor with a cached key schedule
module aes128_iter_decrypt
    import aes_pkg::*;
#(
    parameter bit REUSE_KEY = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] cipher_text,
    input  logic [BLOCK_W-1:0] key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] plain_text,
    output logic               busy
);

    state_t             fsm;
    logic [3:0]         cnt;
    logic               cache_valid;
    logic               key_hit;
    logic [BLOCK_W-1:0] rk [0:NR];
    logic [BLOCK_W-1:0] ct;
    logic [BLOCK_W-1:0] blk;
    logic [BLOCK_W-1:0] prev_rk;
    logic [BLOCK_W-1:0] next_rk;
    logic [BLOCK_W-1:0] round_out;
    logic [31:0]        t, w0, w1, w2, w3;

    assign in_ready  = rst_n && (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm != IDLE);
    assign key_hit   = REUSE_KEY && cache_valid && (key == rk[0]);

    // cnt selects which round key is produced during EXPAND.
    always_comb begin
        prev_rk = rk[cnt - 4'd1];
        t  = {sbox(prev_rk[23:16]) ^ RCON[cnt], sbox(prev_rk[15:8]),
              sbox(prev_rk[7:0]), sbox(prev_rk[31:24])};
        w0 = prev_rk[127:96] ^ t;
        w1 = prev_rk[95:64]  ^ w0;
        w2 = prev_rk[63:32]  ^ w1;
        w3 = prev_rk[31:0]   ^ w2;
        next_rk = {w0, w1, w2, w3};
    end

    aes_inv_round u_round (
        .state      (blk),
        .round_key  (rk[cnt]),
        .last       (cnt == 4'd0),
        .next_state (round_out)
    );

    always_ff @(posedge clk) begin
        if (in_ready && in_valid && !key_hit) rk[0] <= key;
        if (fsm == EXPAND) rk[cnt] <= next_rk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= IDLE;
            cnt         <= 4'd0;
            cache_valid <= 1'b0;
            ct          <= '0;
            blk         <= '0;
            plain_text  <= '0;
        end else begin
            case (fsm)
                IDLE: if (in_valid) begin
                    ct <= cipher_text;
                    if (key_hit) begin
                        fsm <= INIT;
                    end else begin
                        cache_valid <= 1'b0;
                        cnt         <= 4'd1;
                        fsm         <= EXPAND;
                    end
                end
                EXPAND: if (cnt == 4'(NR)) begin
                    cache_valid <= 1'b1;
                    fsm         <= INIT;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                INIT: begin
                    blk <= ct ^ rk[NR];
                    cnt <= 4'(NR - 1);
                    fsm <= ROUND;
                end
                ROUND: if (cnt == 4'd0) begin
                    plain_text <= round_out;
                    fsm        <= DONE;
                end else begin
                    blk <= round_out;
                    cnt <= cnt - 4'd1;
                end
                DONE: if (out_ready) fsm <= IDLE;
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_iter_decrypt.sv
// tb/tb_aes128_iter_decrypt.sv - self-checking bench with a reference AES inverse cipher
module tb_aes128_iter_decrypt;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    // Edges from acceptance to out_valid, counting the accepting edge as the first.
    localparam int LAT_EXP = 22;
    localparam int LAT_HIT = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0, in_valid0 = 1'b0, out_ready = 1'b1;
    logic [127:0] cipher_text = '0, key = '0;
    logic         in_ready, out_valid, busy, in_ready0, out_valid0, busy0;
    logic [127:0] plain_text, plain_text0;

    int checks = 0;
    int failures = 0;

    logic [7:0] sb [256];
    logic [7:0] isb [256];

    int           m_phase = 0;
    int           m_cnt = 0;
    int           m_lat = 0;
    logic         m_cache_ok = 1'b0;
    logic [127:0] m_cache_key = '0;
    logic [127:0] m_exp = '0;
    logic [127:0] m_pt = '0;

    always #5 clk = ~clk;

    aes128_iter_decrypt #(.REUSE_KEY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cipher_text(cipher_text), .key(key), .out_valid(out_valid),
        .out_ready(out_ready), .plain_text(plain_text), .busy(busy));

    aes128_iter_decrypt #(.REUSE_KEY(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .cipher_text(cipher_text), .key(key), .out_valid(out_valid0),
        .out_ready(out_ready), .plain_text(plain_text0), .busy(busy0));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] imul(input logic [7:0] a, input logic [3:0] f);
        logic [7:0] a2, a4, a8;
        a2 = xt(a); a4 = xt(a2); a8 = xt(a4);
        return (f[3] ? a8 : 8'h00) ^ (f[2] ? a4 : 8'h00) ^ (f[1] ? a2 : 8'h00) ^ (f[0] ? a : 8'h00);
    endfunction

    function automatic void build_tables();
        logic [7:0] p, q, x;
        p = 8'h01; q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endfunction

    function automatic logic [127:0] ref_decrypt(input logic [127:0] k, input logic [127:0] ct);
        logic [31:0]  w [44];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]] ^ rc, sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = ct[127 - 8*(4*c + r) -: 8] ^ w[40 + c][31 - 8*r -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = isb[s[r][(c - r + 4) % 4]] ^ w[4*rnd + c][31 - 8*r -: 8];
            for (int c = 0; c < 4; c++) begin
                if (rnd > 0) begin
                    s[0][c] = imul(t[0][c], 4'd14) ^ imul(t[1][c], 4'd11) ^ imul(t[2][c], 4'd13) ^ imul(t[3][c], 4'd9);
                    s[1][c] = imul(t[0][c], 4'd9)  ^ imul(t[1][c], 4'd14) ^ imul(t[2][c], 4'd11) ^ imul(t[3][c], 4'd13);
                    s[2][c] = imul(t[0][c], 4'd13) ^ imul(t[1][c], 4'd9)  ^ imul(t[2][c], 4'd14) ^ imul(t[3][c], 4'd11);
                    s[3][c] = imul(t[0][c], 4'd11) ^ imul(t[1][c], 4'd13) ^ imul(t[2][c], 4'd9)  ^ imul(t[3][c], 4'd14);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8*(4*c + r) -: 8] = s[r][c];
        return res;
    endfunction

    // Transaction-level model: phase 0 idle, 1 working, 2 result presented.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_cnt = 0; m_cache_ok = 1'b0; m_pt = '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_exp = ref_decrypt(key, cipher_text);
                    m_lat = (m_cache_ok && key == m_cache_key) ? LAT_HIT : LAT_EXP;
                    m_cache_key = key;
                    m_cache_ok = 1'b1;
                    m_cnt = 1;
                    m_phase = 1;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == m_lat) begin
                        m_phase = 2;
                        m_pt = m_exp;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("in_ready", {127'd0, in_ready}, {127'd0, (m_phase == 0) && rst_n});
        check("out_valid", {127'd0, out_valid}, {127'd0, m_phase == 2});
        check("busy", {127'd0, busy}, {127'd0, m_phase != 0});
        check("plain_text", plain_text, m_pt);
    end

    task automatic txn(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p,
                       input int lat, input int hold, input int glitch);
        int n;
        key = k; cipher_text = c; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk); #2;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 60) begin
            if (n == glitch) begin
                in_valid = 1'b1;
                cipher_text = c ^ 128'h1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #2;
            n++;
        end
        in_valid = 1'b0;
        check("latency", 128'(n), 128'(lat));
        check("result", plain_text, p);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            check("hold_valid", {127'd0, out_valid}, 128'd1);
            check("hold_in_ready", {127'd0, in_ready}, 128'd0);
            check("hold_data", plain_text, p);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        check("idle_after_ack", {127'd0, in_ready}, 128'd1);
        check("retained", plain_text, p);
    endtask

    task automatic txn0(input int lat);
        int n;
        check("noreuse_ready", {127'd0, in_ready0}, 128'd1);
        key = K1; cipher_text = C1; in_valid0 = 1'b1;
        @(posedge clk); #2;
        in_valid0 = 1'b0;
        check("noreuse_busy", {127'd0, busy0}, 128'd1);
        n = 1;
        while (!out_valid0 && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        check("noreuse_latency", 128'(n), 128'(lat));
        check("noreuse_result", plain_text0, P1);
        @(posedge clk); #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        build_tables();
        check("pin_sbox_53", {120'd0, sb[8'h53]}, 128'hed);
        check("pin_isbox_63", {120'd0, isb[8'h63]}, 128'h00);
        check("pin_model_v1", ref_decrypt(K1, C1), P1);
        check("pin_model_v2", ref_decrypt(K2, C2), P2);

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("ready_after_reset", {127'd0, in_ready}, 128'd1);

        txn(K1, C1, P1, LAT_EXP, 0, 0);
        txn(K1, C1, P1, LAT_HIT, 0, 0);
        txn(K2, C2, P2, LAT_EXP, 0, 0);
        txn(K1, C1, P1, LAT_EXP, 5, 0);
        txn(K1, C1, P1, LAT_HIT, 0, 5);

        key = K1; cipher_text = C1; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("abort_out_valid", {127'd0, out_valid}, 128'd0);
        check("abort_plain_text", plain_text, 128'd0);
        check("abort_in_ready", {127'd0, in_ready}, 128'd1);
        txn(K1, C1, P1, LAT_EXP, 0, 0);

        txn0(LAT_EXP);
        txn0(LAT_EXP);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
